// File: rtl/icache_fetch_arbiter.sv
// Two-requester fetch arbiter in front of a blocking instruction cache, with a flush drain state.
// Optional perf counters are enabled by defining ICACHE_FETCH_ARB_PERF_EN.
module icache_fetch_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            req0_i,
  input  logic [XLEN-1:0] addr0_i,
  output logic            ack0_o,
  output logic [XLEN-1:0] data0_o,
  input  logic            req1_i,
  input  logic [XLEN-1:0] addr1_i,
  output logic            ack1_o,
  output logic [XLEN-1:0] data1_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o,
  output logic            grant_id_o,
  output logic [15:0]     perf_grant0_o,
  output logic [15:0]     perf_grant1_o,
  output logic [15:0]     perf_drop_o
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0]   LIM = CW'(STARVE_LIMIT);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t          state_q;
  logic            mem_req_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            grant_q;
  logic [CW-1:0]   starve_q;

  logic arb_go;
  logic win1;
  logic resp_ok;

  always_comb begin
    arb_go  = (state_q == IDLE) && !flush_i && (req0_i || req1_i);
    win1    = req1_i && (!req0_i || ((STARVE_LIMIT != 0) && (starve_q == LIM)));
    resp_ok = (state_q == BUSY) && mem_ack_i && !flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      grant_q    <= 1'b0;
      starve_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!req1_i) starve_q <= '0;
          if (arb_go) begin
            state_q    <= BUSY;
            mem_req_q  <= 1'b1;
            grant_q    <= win1;
            mem_addr_q <= win1 ? addr1_i : addr0_i;
            if (win1) starve_q <= '0;
            else if (req1_i && (starve_q != LIM)) starve_q <= starve_q + CW'(1);
          end
        end
        BUSY: begin
          // A flush coinciding with the ack just drops the word; otherwise wait it out in DRAIN.
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end else if (flush_i) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != IDLE);
  assign ack0_o     = resp_ok && !grant_q;
  assign ack1_o     = resp_ok && grant_q;
  assign data0_o    = ack0_o ? mem_rdata_i : NOP;
  assign data1_o    = ack1_o ? mem_rdata_i : NOP;

`ifdef ICACHE_FETCH_ARB_PERF_EN
  logic [15:0] perf_grant0_q, perf_grant1_q, perf_drop_q;
  logic        resp_drop;

  assign resp_drop = mem_ack_i && (((state_q == BUSY) && flush_i) || (state_q == DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_drop_q   <= '0;
    end else begin
      if (arb_go && !win1 && (perf_grant0_q != 16'hFFFF)) perf_grant0_q <= perf_grant0_q + 16'd1;
      if (arb_go && win1 && (perf_grant1_q != 16'hFFFF))  perf_grant1_q <= perf_grant1_q + 16'd1;
      if (resp_drop && (perf_drop_q != 16'hFFFF))         perf_drop_q   <= perf_drop_q + 16'd1;
    end
  end

  assign perf_grant0_o = perf_grant0_q;
  assign perf_grant1_o = perf_grant1_q;
  assign perf_drop_o   = perf_drop_q;
`else
  assign perf_grant0_o = 16'h0;
  assign perf_grant1_o = 16'h0;
  assign perf_drop_o   = 16'h0;
`endif

endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// Scoreboard bench for icache_fetch_arbiter: expected responses are queued when the cache ack is
// driven and matched against ack0_o/ack1_o by a monitor sampling mid-cycle.
module tb_icache_fetch_arbiter;
  localparam int XLEN = 32;
  localparam int LIM  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst, flush_i;
  logic        req0_i, req1_i, ack0_o, ack1_o;
  logic [31:0] addr0_i, addr1_i, data0_o, data1_o;
  logic        mem_req_o, mem_ack_i, busy_o, grant_id_o;
  logic [31:0] mem_addr_o, mem_rdata_i;
  logic [15:0] perf_grant0_o, perf_grant1_o, perf_drop_o;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } resp_t;

  resp_t sbQ[$];
  int total = 0;
  int bad = 0;
  int expG0 = 0, expG1 = 0, expDrop = 0;

  icache_fetch_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req0_i(req0_i), .addr0_i(addr0_i), .ack0_o(ack0_o), .data0_o(data0_o),
    .req1_i(req1_i), .addr1_i(addr1_i), .ack1_o(ack1_o), .data1_o(data1_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .grant_id_o(grant_id_o),
    .perf_grant0_o(perf_grant0_o), .perf_grant1_o(perf_grant1_o), .perf_drop_o(perf_drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus, driven on the falling edge, then a short settle for combinational checks.
  task automatic applyStimulus(input logic f, input logic r0, input logic [31:0] a0,
                               input logic r1, input logic [31:0] a1,
                               input logic mack, input logic [31:0] rd);
    @(negedge clk);
    flush_i     = f;
    req0_i      = r0;
    addr0_i     = a0;
    req1_i      = r1;
    addr1_i     = a1;
    mem_ack_i   = mack;
    mem_rdata_i = rd;
    #1;
  endtask

  task automatic expectResp(input logic id, input logic [31:0] data);
    resp_t e;
    e.id   = id;
    e.data = data;
    sbQ.push_back(e);
  endtask

  task automatic checkPerf(input string tag);
`ifdef ICACHE_FETCH_ARB_PERF_EN
    checkOutput({tag, "_g0"}, {16'h0, perf_grant0_o}, expG0);
    checkOutput({tag, "_g1"}, {16'h0, perf_grant1_o}, expG1);
    checkOutput({tag, "_drop"}, {16'h0, perf_drop_o}, expDrop);
`else
    checkOutput({tag, "_g0"}, {16'h0, perf_grant0_o}, 0);
    checkOutput({tag, "_g1"}, {16'h0, perf_grant1_o}, 0);
    checkOutput({tag, "_drop"}, {16'h0, perf_drop_o}, 0);
`endif
  endtask

  // Monitor: every ack must match the head of the scoreboard; idle cycles must show NOP on both ports.
  always @(negedge clk) begin
    #2;
    if (ack0_o || ack1_o) begin
      if (sbQ.size() == 0) begin
        checkOutput("ack_unexpected", {30'b0, ack1_o, ack0_o}, 32'h0);
      end else begin
        resp_t e;
        e = sbQ.pop_front();
        checkOutput("ack_pair", {30'b0, ack1_o, ack0_o}, e.id ? 32'd2 : 32'd1);
        checkOutput("ack_data", e.id ? data1_o : data0_o, e.data);
        checkOutput("ack_other_nop", e.id ? data0_o : data1_o, NOP);
      end
    end else begin
      checkOutput("idle_data0", data0_o, NOP);
      checkOutput("idle_data1", data1_o, NOP);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc;
    logic expId;
    logic [31:0] a0, a1;

    rst = 1'b1; flush_i = 1'b0; req0_i = 1'b0; req1_i = 1'b0; addr0_i = '0; addr1_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    @(negedge clk); #1;
    checkOutput("rst_mem_req", mem_req_o, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_grant", grant_id_o, 0);
    checkOutput("rst_acks", {ack1_o, ack0_o}, 0);
    checkOutput("rst_data0", data0_o, NOP);
    checkOutput("rst_data1", data1_o, NOP);
    checkPerf("rst_perf");
    @(negedge clk);
    rst = 1'b0;

    // Basic demand fetch with one-cycle request latency.
    applyStimulus(0, 1, 32'h8000_0000, 0, 0, 0, 0);
    checkOutput("t1_no_req_yet", mem_req_o, 0);
    applyStimulus(0, 1, 32'h8000_0000, 0, 0, 0, 0);
    expG0++;
    checkOutput("t1_mem_req", mem_req_o, 1);
    checkOutput("t1_mem_addr", mem_addr_o, 32'h8000_0000);
    checkOutput("t1_grant", grant_id_o, 0);
    checkOutput("t1_busy", busy_o, 1);
    expectResp(1'b0, 32'h0000_0297);
    applyStimulus(0, 1, 32'h8000_0000, 0, 0, 1, 32'h0000_0297);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_idle_busy", busy_o, 0);
    checkOutput("t1_idle_req", mem_req_o, 0);

    // Both requesters held: starvation guard forces requester 1 every LIM+1 grants.
    sc = 0;
    for (int k = 0; k < 10; k++) begin
      a0 = 32'h1000 + k * 4;
      a1 = 32'h2000 + k * 4;
      expId = (LIM != 0) && (sc == LIM);
      if (expId) begin
        sc = 0;
        expG1++;
      end else begin
        if (sc < LIM) sc++;
        expG0++;
      end
      applyStimulus(0, 1, a0, 1, a1, 0, 0);
      applyStimulus(0, 1, a0, 1, a1, 0, 0);
      checkOutput("t2_grant", grant_id_o, expId);
      checkOutput("t2_addr", mem_addr_o, expId ? a1 : a0);
      expectResp(expId, 32'hD000_0000 | k);
      applyStimulus(0, 1, a0, 1, a1, 1, 32'hD000_0000 | k);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Flush one cycle after grant: drain, hold request until the late ack, discard it.
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0);
    expG0++;
    applyStimulus(1, 0, 32'h100, 0, 0, 0, 0);
    checkOutput("t3_busy", busy_o, 1);
    checkOutput("t3_addr", mem_addr_o, 32'h100);
    expDrop++;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_drain_req1", mem_req_o, 1);
    checkOutput("t3_drain_busy", busy_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_drain_req2", mem_req_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    checkOutput("t3_drain_req3", mem_req_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_after_busy", busy_o, 0);
    checkOutput("t3_after_req", mem_req_o, 0);

    // Flush in IDLE blocks the grant; flush coinciding with ack suppresses the response.
    applyStimulus(1, 1, 32'h200, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h200, 0, 0, 0, 0);
    checkOutput("t4_idle_flush_nogrant", mem_req_o, 0);
    applyStimulus(1, 1, 32'h300, 0, 0, 1, 32'h5555_5555);
    checkOutput("t4_busy", busy_o, 1);
    checkOutput("t4_addr", mem_addr_o, 32'h200);
    expG0++;
    expDrop++;
    applyStimulus(0, 1, 32'h300, 0, 0, 0, 0);
    checkOutput("t4_idle_after", busy_o, 0);
    applyStimulus(0, 1, 32'h300, 0, 0, 0, 0);
    checkOutput("t4_regrant_req", mem_req_o, 1);
    checkOutput("t4_regrant_addr", mem_addr_o, 32'h300);
    expG0++;
    expectResp(1'b0, 32'h0000_3333);
    applyStimulus(0, 1, 32'h300, 0, 0, 1, 32'h0000_3333);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkPerf("t4_perf");

    // Reset in the middle of a requester-1 transaction; the late ack must be ignored.
    applyStimulus(0, 0, 0, 1, 32'h400, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h400, 0, 0);
    checkOutput("t5_grant", grant_id_o, 1);
    checkOutput("t5_addr", mem_addr_o, 32'h400);
    @(negedge clk);
    rst = 1'b1;
    req1_i = 1'b0;
    #1;
    expG0 = 0; expG1 = 0; expDrop = 0;
    checkOutput("t5_rst_req", mem_req_o, 0);
    checkOutput("t5_rst_addr", mem_addr_o, 0);
    checkOutput("t5_rst_busy", busy_o, 0);
    checkOutput("t5_rst_grant", grant_id_o, 0);
    checkPerf("t5_perf");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hEEEE_EEEE);
    checkOutput("t5_spurious_busy", busy_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_final_busy", busy_o, 0);
    checkOutput("t5_final_req", mem_req_o, 0);

    repeat (2) @(negedge clk);
    #3;
    checkOutput("sb_empty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
